pipeline_stall_controller: RTL
==============================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, range 1..3: number of cycles IF/ID stays flushed after a taken branch.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  single clock for all state; rising-edge.
REQ-004 SHALL have port arst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port load_use_hazard  input  1  load-use stall request from the hazard detection unit.
REQ-006 SHALL have port branch_taken  input  1  taken branch/jump resolved in EX; PC redirect this cycle.
REQ-007 SHALL have port dmem_busy  input  1  data memory multi-cycle access in progress; whole pipeline must hold.
REQ-008 SHALL have port cnt_clear  input  1  synchronous clear of stall_cycles.
REQ-009 SHALL have port pc_write  output  1  PC register load enable.
REQ-010 SHALL have port if_id_write  output  1  IF/ID register load enable.
REQ-011 SHALL have port if_id_flush  output  1  IF/ID contents replaced by NOP.
REQ-012 SHALL have port id_ex_bubble  output  1  ID/EX control fields zeroed (bubble).
REQ-013 SHALL have port pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB registers.
REQ-014 SHALL have port ctrl_state  output  2  current FSM state (RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3).
REQ-015 SHALL have port stall_cycles  output  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-016 SHALL implement FSM states RUN, LOAD_STALL, FLUSH, MEM_WAIT; all outputs combinational from state and current inputs (same-cycle response).
REQ-017 Input priority SHALL be dmem_busy > branch_taken > load_use_hazard in every state.
REQ-018 Default (no event, RUN): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pipe_hold=0.
REQ-019 Any state, dmem_busy=1: pc_write=0, if_id_write=0, pipe_hold=1, if_id_flush=0, id_ex_bubble=0; next state MEM_WAIT; flush counter frozen.
REQ-020 MEM_WAIT with dmem_busy=0: resume as RUN same cycle (branch/load-use re-evaluated), then follow RUN transitions; a frozen FLUSH sequence SHALL resume with its remaining count.
REQ-021 RUN, branch_taken=1: pc_write=1, if_id_flush=1, id_ex_bubble=1; if FLUSH_CYCLES>1 load flush counter with FLUSH_CYCLES-1 and go FLUSH, else stay RUN.
REQ-022 FLUSH: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=0; decrement counter; go RUN when counter reaches 0; a new branch_taken reloads the counter; load_use_hazard ignored.
REQ-023 RUN, load_use_hazard=1 (no higher event): pc_write=0, if_id_write=0, id_ex_bubble=1; next state LOAD_STALL.
REQ-024 LOAD_STALL: load_use_hazard ignored (exactly one bubble per load); outputs as default; next state RUN; branch_taken handled as in RUN.
REQ-025 stall_cycles SHALL increment by 1 on each rising edge where pc_write=0, saturate at 2^CNT_W-1, no wrap.
REQ-026 cnt_clear=1 SHALL load stall_cycles with 0 and take precedence over increment.
REQ-027 if_id_flush and if_id_write SHALL never both be 0 while pipe_hold=0 and pc_write=1.

Reset
REQ-028 arst=1 SHALL immediately force state RUN, flush counter 0, stall_cycles 0, independent of clk.
REQ-029 During reset outputs SHALL equal the RUN default with inputs ignored: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pipe_hold=0.
REQ-030 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abandon the sequence; first cycle after release is RUN.

Verification
REQ-031 Load-use: load_use_hazard=1 held 2 cycles in RUN -> cycle0 pc_write=0, id_ex_bubble=1; cycle1 ctrl_state=1, pc_write=1; stall_cycles=1.
REQ-032 Branch, FLUSH_CYCLES=3: branch_taken pulse -> if_id_flush=1 for 3 consecutive cycles, id_ex_bubble=1 only on first, then ctrl_state=0.
REQ-033 Simultaneous: dmem_busy=1, branch_taken=1, load_use_hazard=1 for 4 cycles -> pipe_hold=1, pc_write=0 all 4 cycles, stall_cycles=4; dmem_busy drops -> branch flush same cycle.
REQ-034 Busy mid-FLUSH (FLUSH_CYCLES=3): dmem_busy 2 cycles after branch cycle -> flush count frozen, remaining flush cycle issued after busy clears.
REQ-035 Counter: CNT_W=4, dmem_busy held 20 cycles -> stall_cycles saturates at 15; cnt_clear with stall active -> 0 next edge.
REQ-036 Async reset: assert arst between edges in MEM_WAIT -> ctrl_state=0, stall_cycles=0 before next clk edge.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush controller for a classic five-stage in-order pipeline.
// It arbitrates three hazard sources and turns them into the register
// enables and kill signals used by the PC and pipeline registers:
//
//   dmem_busy       (highest) - data memory needs extra cycles; freeze all
//   branch_taken              - redirect resolved in EX; kill wrong path
//   load_use_hazard (lowest)  - consumer in ID needs a loaded value; insert
//                               exactly one bubble into ID/EX
//
// Control outputs respond in the same cycle: they are a combinational
// function of the current state and the current hazard inputs. Only the
// state, the flush counter and the stall-cycle statistic are registered.
//
// Parameters
//   FLUSH_CYCLES : cycles IF/ID stays flushed after a taken branch,
//                  including the branch cycle itself (legal range 1..3)
//   CNT_W        : width of the saturating stall-cycle counter
//
// Ports
//   clk             in   rising-edge clock
//   arst            in   asynchronous active-high reset
//   load_use_hazard in   load-use stall request from hazard detection
//   branch_taken    in   taken branch/jump resolved in EX this cycle
//   dmem_busy       in   multi-cycle data memory access in progress
//   cnt_clear       in   synchronous clear of stall_cycles
//   pc_write        out  PC load enable
//   if_id_write     out  IF/ID load enable
//   if_id_flush     out  IF/ID loaded with a NOP
//   id_ex_bubble    out  ID/EX control fields zeroed
//   pipe_hold       out  freeze ID/EX, EX/MEM and MEM/WB
//   ctrl_state      out  current state (RUN=0, LOAD_STALL=1, FLUSH=2,
//                        MEM_WAIT=3)
//   stall_cycles    out  saturating count of cycles with pc_write=0
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

    // The branch cycle is itself the first flush cycle, so the counter only
    // tracks the flush cycles that follow it.
    localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);

    state_t           state_r;
    state_t           state_nxt_s;
    state_t           eff_state_s;
    logic [1:0]       flush_cnt_r;
    logic [1:0]       flush_cnt_nxt_s;
    logic [CNT_W-1:0] stall_cycles_r;

    logic             pc_write_s;
    logic             if_id_write_s;
    logic             if_id_flush_s;
    logic             id_ex_bubble_s;
    logic             pipe_hold_s;

    // Effective behaviour state: once memory stops being busy, MEM_WAIT acts
    // as RUN, unless it interrupted a flush sequence, in which case the
    // frozen flush resumes with whatever count it had left.
    always_comb begin
        eff_state_s = state_r;
        case (state_r)
            ST_MEM_WAIT: begin
                if (flush_cnt_r != 2'd0) begin
                    eff_state_s = ST_FLUSH;
                end else begin
                    eff_state_s = ST_RUN;
                end
            end
            default: begin
                eff_state_s = state_r;
            end
        endcase
    end

    // Hazard arbitration: decides the control outputs and the next state /
    // flush count. Priority is dmem_busy > branch_taken > load_use_hazard.
    always_comb begin
        pc_write_s      = 1'b1;
        if_id_write_s   = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_bubble_s  = 1'b0;
        pipe_hold_s     = 1'b0;
        state_nxt_s     = ST_RUN;
        flush_cnt_nxt_s = flush_cnt_r;

        if (dmem_busy) begin
            // Whole pipeline holds; the flush counter keeps its value so an
            // interrupted flush can pick up where it stopped.
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            pipe_hold_s   = 1'b1;
            state_nxt_s   = ST_MEM_WAIT;
        end else if (branch_taken) begin
            // Redirect: PC loads the target, the wrong-path fetch is killed.
            // Inside a flush the instruction in ID is already a NOP, so no
            // bubble is needed there; the sequence is simply restarted.
            if_id_flush_s   = 1'b1;
            flush_cnt_nxt_s = FLUSH_RELOAD;
            if (eff_state_s == ST_FLUSH) begin
                id_ex_bubble_s = 1'b0;
            end else begin
                id_ex_bubble_s = 1'b1;
            end
            if (FLUSH_RELOAD != 2'd0) begin
                state_nxt_s = ST_FLUSH;
            end else begin
                state_nxt_s = ST_RUN;
            end
        end else begin
            case (eff_state_s)
                ST_FLUSH: begin
                    // Load-use requests are ignored: ID holds a NOP.
                    if_id_flush_s = 1'b1;
                    if (flush_cnt_r <= 2'd1) begin
                        flush_cnt_nxt_s = 2'd0;
                        state_nxt_s     = ST_RUN;
                    end else begin
                        flush_cnt_nxt_s = flush_cnt_r - 2'd1;
                        state_nxt_s     = ST_FLUSH;
                    end
                end
                ST_LOAD_STALL: begin
                    // The bubble was already inserted; a still-asserted
                    // hazard is the same load and must not stall twice.
                    state_nxt_s = ST_RUN;
                end
                ST_RUN: begin
                    if (load_use_hazard) begin
                        pc_write_s     = 1'b0;
                        if_id_write_s  = 1'b0;
                        id_ex_bubble_s = 1'b1;
                        state_nxt_s    = ST_LOAD_STALL;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // Output stage: while reset is asserted the pipeline sees the plain RUN
    // enables regardless of what the hazard inputs are doing.
    always_comb begin
        if (arst) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            pipe_hold    = 1'b0;
        end else begin
            pc_write     = pc_write_s;
            if_id_write  = if_id_write_s;
            if_id_flush  = if_id_flush_s;
            id_ex_bubble = id_ex_bubble_s;
            pipe_hold    = pipe_hold_s;
        end
    end

    // State and flush counter registers; reset abandons any sequence.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

    // Stall statistic: counts cycles where the PC did not advance, holding
    // at full scale instead of wrapping; clear wins over increment.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (cnt_clear) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (!pc_write_s && (stall_cycles_r != CNT_MAX)) begin
            stall_cycles_r <= stall_cycles_r + CNT_ONE;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign ctrl_state   = state_r;
    assign stall_cycles = stall_cycles_r;

endmodule
